mult_unit: RTL and testbench

Sequential radix-2 shift-add multiplier for the RV32M integer ALU. It is the companion of the non-restoring divide unit and uses the same data_valid / data_ready handshake.
Covers MUL, MULH, MULHSU and MULHU. Operands are converted to magnitudes, multiplied unsigned over XLEN iterations, sign-corrected, and the requested half of the 2*XLEN product is returned.
Sits beside the divider in the Integer ALU; the issue logic drives it directly.

---
 rtl/mult_unit_pkg.sv | 18 +
 rtl/mult_unit.sv | 106 ++++++++++
 tb/tb_mult_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mult_unit_pkg.sv
// Shared integer-ALU definitions: datapath width, multiply op encodings, multiplier FSM states.
package mult_unit_pkg;

  localparam int ALU_XLEN = 32;

  // Encodings match funct3[1:0] of the RV32M multiply instructions.
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_MULT    = 2'b01,
    ST_CORRECT = 2'b10
  } mult_state_t;

endpackage

// File: rtl/mult_unit.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU; result XLEN+1 cycles after accept.
// Requests arriving while busy are dropped; data_ready is a single-cycle pulse.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int XLEN        = mult_unit_pkg::ALU_XLEN,
  parameter int COUNT_WIDTH = 5
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  input  logic [1:0]      op,
  input  logic            data_valid,
  output logic [XLEN-1:0] product,
  output logic            data_ready,
  output logic            busy
);

  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

  mult_state_t            state_q;
  logic [XLEN-1:0]        mcand_q;
  logic [XLEN-1:0]        mplr_q;
  logic [2*XLEN-1:0]      acc_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [1:0]             op_q;
  logic                   neg_q;
  logic [XLEN-1:0]        product_q;
  logic                   data_ready_q;
  logic                   busy_q;

  logic                   mcand_neg;
  logic                   mplr_neg;
  logic [XLEN-1:0]        mcand_mag;
  logic [XLEN-1:0]        mplr_mag;
  logic [XLEN:0]          add_sum;
  logic [2*XLEN-1:0]      acc_d;
  logic [2*XLEN-1:0]      prod_full;

  always_comb begin
    mcand_neg = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && multiplicand[XLEN-1];
    mplr_neg  = (op == MUL_OP_MULH) && multiplier[XLEN-1];
    // Negating the most negative value yields itself, read back as an unsigned magnitude.
    mcand_mag = mcand_neg ? (~multiplicand + ONE_X) : multiplicand;
    mplr_mag  = mplr_neg  ? (~multiplier + ONE_X)   : multiplier;

    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mplr_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    acc_d     = {add_sum, acc_q[XLEN-1:1]};
    prod_full = neg_q ? (~acc_q + ONE_2X) : acc_q;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mcand_q      <= '0;
      mplr_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      op_q         <= MUL_OP_MUL;
      neg_q        <= 1'b0;
      product_q    <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_ready_q <= 1'b0;
          if (data_valid) begin
            mcand_q <= mcand_mag;
            mplr_q  <= mplr_mag;
            neg_q   <= mcand_neg ^ mplr_neg;
            op_q    <= op;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_MULT;
          end
        end
        ST_MULT: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q + COUNT_WIDTH'(1);
          if (cnt_q == '1) begin
            state_q <= ST_CORRECT;
          end
        end
        ST_CORRECT: begin
          product_q    <= (op_q == MUL_OP_MUL) ? prod_full[XLEN-1:0] : prod_full[2*XLEN-1:XLEN];
          data_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign product    = product_q;
  assign data_ready = data_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed table, handshake corner sequences, random ops vs. arithmetic model.
module tb_mult_unit;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            CLK = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic [1:0]      op;
  logic            data_valid;
  logic [XLEN-1:0] product;
  logic            data_ready;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mult_unit #(.XLEN(XLEN), .COUNT_WIDTH(5)) dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op           (op),
    .data_valid   (data_valid),
    .product      (product),
    .data_ready   (data_ready),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: exact signed/unsigned product from the op's operand interpretation.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    eb = (o == 2'b01)               ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Drives a request for one accepting edge, then scrambles the inputs.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op           = o;
    multiplicand = a;
    multiplier   = b;
    data_valid   = 1'b1;
    @(posedge CLK);
    #1;
    data_valid   = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    op           = 2'($urandom_range(0, 3));
  endtask

  // Counts edges from the accept edge until data_ready, bounded.
  task automatic wait_done(output logic [31:0] res, output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (data_ready !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge CLK);
      #1;
      lat++;
    end
    res = product;
  endtask

  vec_t        vecs[9];
  logic [31:0] res;
  int          lat;
  bit          busy_ok;
  bit          saw_ready;

  initial begin
    vecs[0] = '{2'b00, 32'd7,          32'd6,          32'h0000002A};
    vecs[1] = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
    vecs[2] = '{2'b01, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000};
    vecs[3] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
    vecs[4] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
    vecs[5] = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
    vecs[6] = '{2'b00, 32'h80000000,   32'h80000000,   32'h00000000};
    vecs[7] = '{2'b11, 32'h00000000,   32'h12345678,   32'h00000000};
    vecs[8] = '{2'b01, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF};

    rst_n        = 1'b0;
    data_valid   = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    op           = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy",       {31'b0, busy},       32'd0);
    check("reset_data_ready", {31'b0, data_ready}, 32'd0);
    check("reset_product",    product,             32'd0);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(res, lat, busy_ok);
      check($sformatf("vec%0d_product", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_busy", i), {31'b0, busy_ok}, 32'd1);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d_pulse_width", i), {31'b0, data_ready}, 32'd0);
    end

    // A request 10 cycles into an operation is dropped.
    start_op(2'b00, 32'd3, 32'd4);
    repeat (10) @(posedge CLK);
    #1;
    op = 2'b00; multiplicand = 32'd5; multiplier = 32'd5; data_valid = 1'b1;
    @(posedge CLK);
    #1;
    data_valid = 1'b0;
    wait_done(res, lat, busy_ok);
    check("ignore_product", res, 32'h0000000C);
    check("ignore_latency", lat, LAT - 11);

    // Back-to-back issue while data_ready is still high.
    start_op(2'b00, 32'd5, 32'd5);
    wait_done(res, lat, busy_ok);
    check("b2b_product", res, 32'h00000019);
    check("b2b_latency", lat, LAT);

    // Reset at iteration 10 discards the in-flight operation.
    @(posedge CLK);
    #1;
    start_op(2'b00, 32'd3, 32'd7);
    repeat (10) @(posedge CLK);
    #1;
    rst_n = 1'b0;
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    check("midreset_busy",    {31'b0, busy},    32'd0);
    check("midreset_product", product,          32'd0);
    saw_ready = 1'b0;
    repeat (40) begin
      if (data_ready === 1'b1 || busy === 1'b1) saw_ready = 1'b1;
      @(posedge CLK);
      #1;
    end
    check("midreset_no_pulse", {31'b0, saw_ready}, 32'd0);

    start_op(2'b11, 32'h00010000, 32'h00010000);
    wait_done(res, lat, busy_ok);
    check("post_reset_product", res, 32'h00000001);
    check("post_reset_latency", lat, LAT);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = (i % 2 == 0) ? 32'h80000000 : 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) b = (i % 3 == 0) ? 32'h00000000 : 32'h80000000;
      start_op(o, a, b);
      wait_done(res, lat, busy_ok);
      check($sformatf("rand%0d_op%0d_%08h_%08h", i, o, a, b), res, ref_mul(o, a, b));
      check($sformatf("rand%0d_latency", i), lat, LAT);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
